lap_stopwatch_datapath: RTL and testbench

- Parametrised successor to the single-lap stopwatch datapath, driven each cycle by a control word from the stopwatch FSM.
- Holds a DIGITS-wide BCD counter that counts up or down, a tick prescaler and a LAP_DEPTH-deep circular lap buffer with recall.
- Drives one active-low seven-segment code per digit, showing either the live count or a recalled lap.
- Sits between the stopwatch FSM (which consumes tick and issues cw) and the board display.

---
 rtl/stopwatch_defs.sv | 65 ++++++
 rtl/lap_stopwatch_datapath_if.sv | 39 +++
 rtl/bcd_to_sevenseg.sv | 29 ++
 rtl/lap_stopwatch_datapath.sv | 171 +++++++++++++++++
 tb/tb_lap_stopwatch_datapath.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_defs.sv
// ---------------------------------------------------------------------------
// stopwatch_defs
// Shared definitions for the lap stopwatch datapath: control-word layout,
// prescaler mode encoding, seven-segment blank code and the per-digit BCD
// step helper used by the counter chain.
// No ports (package).
// ---------------------------------------------------------------------------
package stopwatch_defs;

    localparam int CW_WIDTH = 8;

    // Bit positions inside the control word issued by the stopwatch FSM.
    localparam int CW_PRE_LSB  = 0;
    localparam int CW_PRE_MSB  = 1;
    localparam int CW_ADVANCE  = 2;
    localparam int CW_CLEAR    = 3;
    localparam int CW_PUSH     = 4;
    localparam int CW_SHOW_LAP = 5;
    localparam int CW_DOWN     = 6;
    localparam int CW_RECALL   = 7;

    // Prescaler modes carried in cw[1:0]; 2'b10 is reserved and behaves as hold.
    typedef enum logic [1:0] {
        PRE_HOLD = 2'b00,
        PRE_DOWN = 2'b01,
        PRE_RSVD = 2'b10,
        PRE_LOAD = 2'b11
    } pre_mode_e;

    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    typedef struct packed {
        logic [3:0] digit;
        logic       carry;
    } bcd_step_t;

    // One BCD digit of a ripple up/down chain. carry means "carry" when
    // counting up and "borrow" when counting down.
    function automatic bcd_step_t bcd_step(input logic [3:0] d,
                                           input logic       cin,
                                           input logic       down);
        bcd_step_t r;
        r.digit = d;
        r.carry = 1'b0;
        if (cin) begin
            if (!down) begin
                if (d >= 4'd9) begin
                    r.digit = 4'd0;
                    r.carry = 1'b1;
                end else begin
                    r.digit = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    r.digit = 4'd9;
                    r.carry = 1'b1;
                end else begin
                    r.digit = d - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_stopwatch_datapath_if.sv
// ---------------------------------------------------------------------------
// lap_stopwatch_datapath_if
// Bundle between the stopwatch FSM / display side and the datapath.
//   cw        control word from the FSM
//   tick      prescaler terminal count
//   wrap      one-cycle pulse after the BCD chain wraps
//   lap_count number of valid laps (saturates at LAP_DEPTH)
//   lap_age   recall position, 0 = newest
//   hex       active-low seven-segment codes, digit 0 in [6:0]
// Protocol: there is no valid/ready handshake. cw is sampled on every rising
// edge and its register effects are visible after that edge; the outputs are
// always valid and are read by the consumer whenever it needs them.
// ---------------------------------------------------------------------------
interface lap_stopwatch_datapath_if #(
    parameter int DIGITS    = 3,
    parameter int LAP_DEPTH = 4
);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int AGE_W = $clog2(LAP_DEPTH);

    logic [stopwatch_defs::CW_WIDTH-1:0] cw;
    logic                                tick;
    logic                                wrap;
    logic [CNT_W-1:0]                    lap_count;
    logic [AGE_W-1:0]                    lap_age;
    logic [7*DIGITS-1:0]                 hex;

    // FSM / display side.
    modport master (
        output cw,
        input  tick, wrap, lap_count, lap_age, hex
    );

    // Datapath side.
    modport slave (
        input  cw,
        output tick, wrap, lap_count, lap_age, hex
    );
endinterface

// File: rtl/bcd_to_sevenseg.sv
// ---------------------------------------------------------------------------
// bcd_to_sevenseg
// Combinational BCD to seven-segment decoder, active-low, bit0 = segment a.
//   bcd_i  4-bit digit value
//   seg_o  segment code; values 10-15 decode to all segments off
// ---------------------------------------------------------------------------
module bcd_to_sevenseg
    import stopwatch_defs::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = BLANK_SEG;
        case (bcd_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = BLANK_SEG;
        endcase
    end
endmodule

// File: rtl/lap_stopwatch_datapath.sv
// ---------------------------------------------------------------------------
// lap_stopwatch_datapath
// Stopwatch datapath: tick prescaler, DIGITS-wide up/down BCD counter with
// wrap pulse, LAP_DEPTH-deep circular lap buffer with recall, and a
// seven-segment display mux showing either the live count or a recalled lap.
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     lap_stopwatch_datapath_if.slave (cw in; tick, wrap, lap_count,
//           lap_age, hex out)
// ---------------------------------------------------------------------------
module lap_stopwatch_datapath
    import stopwatch_defs::*;
#(
    parameter int DIGITS    = 3,
    parameter int LAP_DEPTH = 4,
    parameter int TICK_DIV  = 5
)
(
    input  logic                    clk,
    input  logic                    resetn,
    lap_stopwatch_datapath_if.slave bus
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int PTR_W = $clog2(LAP_DEPTH);

    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAP_FULL   = CNT_W'(LAP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(LAP_DEPTH - 1);

    // Control word decode.
    logic      advance, clear, push, show_lap, down, recall;
    pre_mode_e pre_mode;

    assign pre_mode = pre_mode_e'(bus.cw[CW_PRE_MSB:CW_PRE_LSB]);
    assign advance  = bus.cw[CW_ADVANCE];
    assign clear    = bus.cw[CW_CLEAR];
    assign push     = bus.cw[CW_PUSH];
    assign show_lap = bus.cw[CW_SHOW_LAP];
    assign down     = bus.cw[CW_DOWN];
    assign recall   = bus.cw[CW_RECALL];

    // State.
    logic [PRE_W-1:0]                      pre_q, pre_d;
    logic [DIGITS-1:0][3:0]                bcd_q, bcd_d;
    logic                                  wrap_q, wrap_d;
    logic [LAP_DEPTH-1:0][DIGITS-1:0][3:0] laps_q, laps_d;
    logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                      lap_count_q, lap_count_d;
    logic [PTR_W-1:0]                      lap_age_q, lap_age_d;

    // Prescaler: in count-down mode it sits at 0 for exactly one cycle
    // (tick high) and reloads on the following edge.
    always_comb begin
        pre_d = pre_q;
        case (pre_mode)
            PRE_DOWN: pre_d = (pre_q == '0) ? PRE_RELOAD : pre_q - PRE_W'(1);
            PRE_LOAD: pre_d = PRE_RELOAD;
            default:  pre_d = pre_q;
        endcase
    end

    // BCD chain. The carry/borrow leaving the top digit is set only when
    // every digit rolled over, which is exactly the wrap condition.
    logic [DIGITS-1:0][3:0] stepped;
    logic                   chain_carry;

    always_comb begin
        bcd_step_t st;
        stepped     = bcd_q;
        chain_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            st          = bcd_step(bcd_q[i], chain_carry, down);
            stepped[i]  = st.digit;
            chain_carry = st.carry;
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (advance) begin
            bcd_d  = stepped;
            wrap_d = chain_carry;
        end
    end

    // Lap buffer. A push stores the value held before this edge, so an
    // advance in the same cycle does not leak into the stored lap.
    logic [CNT_W-1:0] age_inc;

    always_comb begin
        laps_d      = laps_q;
        wr_ptr_d    = wr_ptr_q;
        lap_count_d = lap_count_q;
        lap_age_d   = lap_age_q;
        age_inc     = CNT_W'(lap_age_q) + CNT_W'(1);
        if (clear && push) begin
            // Clear-with-push empties the lap history instead of writing.
            lap_count_d = '0;
            lap_age_d   = '0;
        end else if (push) begin
            laps_d[wr_ptr_q] = bcd_q;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (lap_count_q != LAP_FULL) begin
                lap_count_d = lap_count_q + CNT_W'(1);
            end
            lap_age_d = '0;
        end else if (recall && (lap_count_q != '0)) begin
            lap_age_d = (age_inc >= lap_count_q) ? '0 : PTR_W'(age_inc);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q       <= PRE_RELOAD;
            bcd_q       <= '0;
            wrap_q      <= 1'b0;
            laps_q      <= '0;
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
            lap_age_q   <= '0;
        end else begin
            pre_q       <= pre_d;
            bcd_q       <= bcd_d;
            wrap_q      <= wrap_d;
            laps_q      <= laps_d;
            wr_ptr_q    <= wr_ptr_d;
            lap_count_q <= lap_count_d;
            lap_age_q   <= lap_age_d;
        end
    end

    // Recall index = (wr_ptr - 1 - age) mod LAP_DEPTH; the 2*LAP_DEPTH bias
    // keeps the sum non-negative so the modulo works for any depth.
    logic [PTR_W-1:0] rd_idx;

    always_comb begin
        int rd_sum;
        rd_sum = int'(wr_ptr_q) + 2 * LAP_DEPTH - 1 - int'(lap_age_q);
        rd_idx = PTR_W'(rd_sum % LAP_DEPTH);
    end

    logic blank_all;
    assign blank_all = show_lap && (lap_count_q == '0);

    wire [7*DIGITS-1:0] hex_w;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] digit_sel;
        logic [6:0] seg;

        assign digit_sel = show_lap ? laps_q[rd_idx][g] : bcd_q[g];

        bcd_to_sevenseg u_dec (
            .bcd_i (digit_sel),
            .seg_o (seg)
        );

        assign hex_w[7*g +: 7] = blank_all ? BLANK_SEG : seg;
    end

    assign bus.tick      = (pre_q == '0);
    assign bus.wrap      = wrap_q;
    assign bus.lap_count = lap_count_q;
    assign bus.lap_age   = lap_age_q;
    assign bus.hex       = hex_w;

endmodule

// File: tb/tb_lap_stopwatch_datapath.sv
// ---------------------------------------------------------------------------
// tb_lap_stopwatch_datapath
// Directed bench for lap_stopwatch_datapath (DIGITS=3, LAP_DEPTH=4,
// TICK_DIV=5). Expected display codes are built from decimal values by a
// bench-side encoder, queued when a step is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_lap_stopwatch_datapath;
    localparam int DIGITS    = 3;
    localparam int LAP_DEPTH = 4;
    localparam int TICK_DIV  = 5;
    localparam int HEX_W     = 7 * DIGITS;

    // Control words used by the sequence.
    localparam logic [7:0] CW_IDLE      = 8'h00;
    localparam logic [7:0] CW_PRE_DOWN  = 8'h01;
    localparam logic [7:0] CW_PRE_LOAD  = 8'h03;
    localparam logic [7:0] CW_UP        = 8'h04;
    localparam logic [7:0] CW_CLR_ADV   = 8'h0C;
    localparam logic [7:0] CW_PUSH      = 8'h10;
    localparam logic [7:0] CW_PUSH_ADV  = 8'h14;
    localparam logic [7:0] CW_CLR_PUSH  = 8'h18;
    localparam logic [7:0] CW_SHOW      = 8'h20;
    localparam logic [7:0] CW_DOWN      = 8'h44;
    localparam logic [7:0] CW_PUSH_REC  = 8'h90;
    localparam logic [7:0] CW_SHOW_REC  = 8'hA0;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [HEX_W-1:0] exp_q[$];

    lap_stopwatch_datapath_if #(.DIGITS(DIGITS), .LAP_DEPTH(LAP_DEPTH)) bus ();

    lap_stopwatch_datapath #(
        .DIGITS    (DIGITS),
        .LAP_DEPTH (LAP_DEPTH),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / reset block.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Reference seven-segment encoding (active-low, bit0 = a).
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal value to full display code; negative means all digits blank.
    function automatic logic [HEX_W-1:0] enc(input int v);
        logic [HEX_W-1:0] r;
        int d;
        r = '1;
        if (v >= 0) begin
            d = v;
            for (int i = 0; i < DIGITS; i++) begin
                r[7*i +: 7] = seg_of(d % 10);
                d = d / 10;
            end
        end
        return r;
    endfunction

    // Scoreboard compare.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply cw half a cycle before the edge, return #1 after it.
    task automatic step(input logic [7:0] c);
        @(negedge clk);
        bus.cw = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(enc(v));
    endtask

    task automatic chk_hex(input string tag);
        logic [HEX_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %0h expected <queue empty>", tag, bus.hex);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus.hex), 32'(e));
        end
    endtask

    task automatic step_hex(input logic [7:0] c, input int v, input string tag);
        push_exp(v);
        step(c);
        chk_hex(tag);
    endtask

    initial begin
        int exp_recall[4];
        exp_recall = '{4, 3, 2, 5};
        bus.cw = CW_IDLE;

        // Reset takes effect without a clock edge (first posedge is at 5).
        #1 resetn = 1'b0;
        #1;
        push_exp(0);
        chk_hex("reset_hex");
        chk("reset_tick", bus.tick, 0);
        chk("reset_lap_count", bus.lap_count, 0);
        chk("reset_wrap", bus.wrap, 0);
        chk("reset_lap_age", bus.lap_age, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Prescaler: load 4, then count down; tick on every 5th step.
        step(CW_PRE_LOAD);
        chk("pre_after_load", bus.tick, 0);
        for (int k = 1; k <= 9; k++) begin
            step(CW_PRE_DOWN);
            chk("pre_tick", bus.tick, (k % 5) == 4);
        end
        for (int k = 0; k < 3; k++) begin
            step(CW_IDLE);
            chk("pre_hold_tick", bus.tick, 1);
        end

        // Count up through every value to 999.
        for (int i = 1; i <= 999; i++) begin
            step_hex(CW_UP, i, "up_count");
            chk("up_no_wrap", bus.wrap, 0);
        end
        step_hex(CW_UP, 0, "up_wrap_hex");
        chk("up_wrap_pulse", bus.wrap, 1);
        step_hex(CW_IDLE, 0, "up_wrap_after");
        chk("up_wrap_one_cycle", bus.wrap, 0);

        // Clear beats advance and never signals wrap.
        for (int i = 1; i <= 5; i++) step_hex(CW_UP, i, "to_five");
        step_hex(CW_CLR_ADV, 0, "clr_priority");
        chk("clr_no_wrap", bus.wrap, 0);

        // Count down across zero.
        step_hex(CW_DOWN, 999, "down_wrap_hex");
        chk("down_wrap_pulse", bus.wrap, 1);
        step_hex(CW_DOWN, 998, "down_next");
        chk("down_wrap_clear", bus.wrap, 0);

        // Laps at counts 1..5 into a 4-deep buffer.
        step_hex(CW_CLR_PUSH, 0, "lap_init_clear");
        chk("lap_init_count", bus.lap_count, 0);
        for (int v = 1; v <= 5; v++) begin
            step_hex(CW_UP, v, "lap_live");
            step(CW_PUSH);
            chk("lap_count", bus.lap_count, (v < LAP_DEPTH) ? v : LAP_DEPTH);
        end
        step_hex(CW_SHOW, 5, "show_newest");
        chk("show_age0", bus.lap_age, 0);
        for (int k = 0; k < 4; k++) begin
            step_hex(CW_SHOW_REC, exp_recall[k], "recall_hex");
            chk("recall_age", bus.lap_age, (k + 1) % 4);
        end
        step(CW_SHOW_REC);
        chk("recall_age_pre_push", bus.lap_age, 1);
        step_hex(CW_PUSH_REC, 5, "push_recall_live");
        chk("push_recall_age", bus.lap_age, 0);
        chk("push_recall_count", bus.lap_count, 4);
        step_hex(CW_SHOW, 5, "push_recall_entry");

        // Push together with advance stores the pre-advance value.
        step_hex(CW_UP, 6, "to_six");
        step_hex(CW_UP, 7, "to_seven");
        step_hex(CW_PUSH_ADV, 8, "push_adv_live");
        step_hex(CW_SHOW, 7, "push_adv_lap");

        // Clearing laps blanks the lap view; recall with no laps is ignored.
        step_hex(CW_CLR_PUSH, 0, "clr_laps_live");
        chk("clr_laps_count", bus.lap_count, 0);
        chk("clr_laps_age", bus.lap_age, 0);
        step_hex(CW_SHOW, -1, "lap_blank");
        step_hex(CW_SHOW_REC, -1, "recall_empty_hex");
        chk("recall_empty_age", bus.lap_age, 0);

        // Build up non-reset state, then reset between edges.
        step(CW_PRE_LOAD);
        for (int k = 0; k < 4; k++) step(CW_PRE_DOWN);
        chk("mid_tick_high", bus.tick, 1);
        step_hex(CW_PUSH_ADV, 1, "mid_push");
        chk("mid_lap_count", bus.lap_count, 1);
        step_hex(CW_DOWN, 0, "mid_down0");
        step_hex(CW_DOWN, 999, "mid_down_wrap");
        chk("mid_wrap_high", bus.wrap, 1);
        bus.cw = CW_IDLE;
        #1 resetn = 1'b0;
        #1;
        push_exp(0);
        chk_hex("midreset_hex");
        chk("midreset_tick", bus.tick, 0);
        chk("midreset_wrap", bus.wrap, 0);
        chk("midreset_lap_count", bus.lap_count, 0);
        chk("midreset_lap_age", bus.lap_age, 0);
        @(negedge clk);
        resetn = 1'b1;
        step_hex(CW_SHOW, -1, "post_reset_blank");
        step_hex(CW_IDLE, 0, "post_reset_live");

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
